pipeline_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline. It drives enable and flush for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB registers. It handles debug-unit run/step commands, load-use stalls, taken-branch flushes, and halt-instruction drain. It also provides a committed-cycle counter to the debug unit.

---
 rtl/pipeline_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Purpose : central sequencer for the five-stage pipeline (run/step, stall, flush, halt drain).
// Latency : enables/flushes are combinational from state and inputs; state and counter update next edge.
// Backpressure: freezes every pipeline register (all enables low) whenever the core is not active.
//
// Ports:
//   clk, rst (async, active-low)    - clock and reset
//   i_run / i_step                  - debug-unit pulses; step wins when both arrive together
//   i_halt_instr                    - halt opcode sitting in ID
//   i_load_use                      - hazard unit load-use stall request
//   i_taken                         - resolved taken branch/jump from EX_MEM
//   o_pc_enable, o_pc_src           - PC update enable and jump-address select
//   o_*_enable / o_*_flush          - per-register enable and flush
//   o_halted, o_running             - status to the debug unit
//   o_cycle_count                   - active cycles since reset (wraps)
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_BITS     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_run,
    input  logic                i_step,
    input  logic                i_halt_instr,
    input  logic                i_load_use,
    input  logic                i_taken,
    output logic                o_pc_enable,
    output logic                o_pc_src,
    output logic                o_if_id_enable,
    output logic                o_if_id_flush,
    output logic                o_id_ex_enable,
    output logic                o_id_ex_flush,
    output logic                o_ex_mem_enable,
    output logic                o_ex_mem_flush,
    output logic                o_mem_wb_enable,
    output logic                o_halted,
    output logic                o_running,
    output logic [CNT_BITS-1:0] o_cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t        state;
    logic          run_mode;
    logic          run_mode_nxt;
    logic [DW-1:0] drain_cnt;
    logic          active;
    logic          halt_take;

    // Step has priority over run when both pulse in the same cycle.
    assign run_mode_nxt = i_step ? 1'b0 : (i_run ? 1'b1 : run_mode);

    // A step while running pauses: that cycle is not active. Gating with rst
    // forces every output low the instant reset asserts, even if i_step is high.
    assign active = rst & ( ((state == RUN) & ~i_step)
                          | ((state == IDLE) & i_step)
                          | ((state == DRAIN) & (run_mode | i_step)) );

    assign o_halted  = rst & (state == HALTED);
    assign o_running = rst & ((state == RUN) | ((state == DRAIN) & run_mode));

    always_comb begin
        o_pc_enable     = 1'b0;
        o_pc_src        = 1'b0;
        o_if_id_enable  = 1'b0;
        o_if_id_flush   = 1'b0;
        o_id_ex_enable  = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_ex_mem_enable = 1'b0;
        o_ex_mem_flush  = 1'b0;
        o_mem_wb_enable = 1'b0;
        halt_take       = 1'b0;
        if (active) begin
            o_pc_enable     = 1'b1;
            o_if_id_enable  = 1'b1;
            o_id_ex_enable  = 1'b1;
            o_ex_mem_enable = 1'b1;
            o_mem_wb_enable = 1'b1;
            if (i_taken) begin
                // Wrong-path instructions in IF_ID/ID_EX/EX_MEM are squashed.
                o_pc_src       = 1'b1;
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
            end else if (i_load_use) begin
                // Hold PC and IF_ID, inject a bubble into ID_EX.
                o_pc_enable    = 1'b0;
                o_if_id_enable = 1'b0;
                o_id_ex_flush  = 1'b1;
            end else if (state == DRAIN) begin
                o_pc_enable   = 1'b0;
                o_if_id_flush = 1'b1;
            end else if (i_halt_instr) begin
                o_pc_enable   = 1'b0;
                o_if_id_flush = 1'b1;
                halt_take     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            run_mode      <= 1'b0;
            drain_cnt     <= '0;
            o_cycle_count <= '0;
        end else begin
            if (state != HALTED) begin
                run_mode <= run_mode_nxt;
            end
            if (active) begin
                o_cycle_count <= o_cycle_count + CNT_BITS'(1);
            end
            case (state)
                IDLE: begin
                    if (i_step) begin
                        if (halt_take) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(DRAIN_CYCLES - 1);
                        end
                    end else if (i_run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (i_step) begin
                        state <= IDLE;
                    end else if (halt_take) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (active) begin
                        if (i_taken) begin
                            // The halt was on the wrong path: resume where we were.
                            state     <= run_mode_nxt ? RUN : IDLE;
                            drain_cnt <= '0;
                        end else if (drain_cnt == '0) begin
                            state <= HALTED;
                        end else begin
                            drain_cnt <= drain_cnt - DW'(1);
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose : directed self-checking bench for pipeline_ctrl.
// Latency : inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic        i_run, i_step, i_halt_instr, i_load_use, i_taken;
    logic        o_pc_enable, o_pc_src;
    logic        o_if_id_enable, o_if_id_flush;
    logic        o_id_ex_enable, o_id_ex_flush;
    logic        o_ex_mem_enable, o_ex_mem_flush;
    logic        o_mem_wb_enable;
    logic        o_halted, o_running;
    logic [31:0] o_cycle_count;

    int total = 0;
    int bad   = 0;

    // {pc_en, pc_src, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, ex_mem_fl, mem_wb_en}
    logic [8:0] ctl;
    assign ctl = {o_pc_enable, o_pc_src, o_if_id_enable, o_if_id_flush,
                  o_id_ex_enable, o_id_ex_flush, o_ex_mem_enable, o_ex_mem_flush,
                  o_mem_wb_enable};

    localparam logic [8:0] CTL_OFF   = 9'b000000000;
    localparam logic [8:0] CTL_ALL   = 9'b101010101;
    localparam logic [8:0] CTL_LU    = 9'b000011101;
    localparam logic [8:0] CTL_TAKEN = 9'b111111111;
    localparam logic [8:0] CTL_HALT  = 9'b001110101;

    pipeline_ctrl #(.DRAIN_CYCLES(4), .CNT_BITS(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_run           (i_run),
        .i_step          (i_step),
        .i_halt_instr    (i_halt_instr),
        .i_load_use      (i_load_use),
        .i_taken         (i_taken),
        .o_pc_enable     (o_pc_enable),
        .o_pc_src        (o_pc_src),
        .o_if_id_enable  (o_if_id_enable),
        .o_if_id_flush   (o_if_id_flush),
        .o_id_ex_enable  (o_id_ex_enable),
        .o_id_ex_flush   (o_id_ex_flush),
        .o_ex_mem_enable (o_ex_mem_enable),
        .o_ex_mem_flush  (o_ex_mem_flush),
        .o_mem_wb_enable (o_mem_wb_enable),
        .o_halted        (o_halted),
        .o_running       (o_running),
        .o_cycle_count   (o_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_run = 1'b0; i_step = 1'b0; i_halt_instr = 1'b0; i_load_use = 1'b0; i_taken = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        clear_inputs();
        #2;
        i_step = 1'b1;
        #1;
        chk("reset_ctl_with_step", 32'(ctl), 32'(CTL_OFF));
        chk("reset_cnt", o_cycle_count, 32'd0);
        chk("reset_halted", 32'(o_halted), 32'd0);
        i_step = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (10) tick();
        chk("idle_ctl", 32'(ctl), 32'(CTL_OFF));
        chk("idle_cnt", o_cycle_count, 32'd0);
        chk("idle_running", 32'(o_running), 32'd0);

        // ---------------- run ----------------
        i_run = 1'b1;
        #1;
        chk("run_pulse_inactive", 32'(ctl), 32'(CTL_OFF));
        tick();
        i_run = 1'b0;
        #1;
        chk("run_all_en", 32'(ctl), 32'(CTL_ALL));
        chk("run_running", 32'(o_running), 32'd1);
        repeat (5) tick();
        chk("run_cnt5", o_cycle_count, 32'd5);
        chk("run_running5", 32'(o_running), 32'd1);

        // load-use stall
        i_load_use = 1'b1;
        #1;
        chk("load_use_ctl", 32'(ctl), 32'(CTL_LU));
        tick();                         // cnt 6
        i_load_use = 1'b0;
        #1;
        chk("after_lu_ctl", 32'(ctl), 32'(CTL_ALL));

        // taken beats load-use
        i_taken = 1'b1; i_load_use = 1'b1;
        #1;
        chk("taken_lu_ctl", 32'(ctl), 32'(CTL_TAKEN));
        tick();                         // cnt 7
        clear_inputs();
        #1;
        chk("after_taken_ctl", 32'(ctl), 32'(CTL_ALL));
        tick();                         // cnt 8

        // halt and drain in run mode
        i_halt_instr = 1'b1;
        #1;
        chk("halt_ctl", 32'(ctl), 32'(CTL_HALT));
        tick();                         // cnt 9, DRAIN entered
        i_halt_instr = 1'b0;
        #1;
        chk("drain_ctl", 32'(ctl), 32'(CTL_HALT));
        chk("drain_running", 32'(o_running), 32'd1);
        repeat (3) tick();              // cnt 12
        chk("drain3_not_halted", 32'(o_halted), 32'd0);
        tick();                         // cnt 13, HALTED
        chk("halted", 32'(o_halted), 32'd1);
        chk("halted_ctl", 32'(ctl), 32'(CTL_OFF));
        chk("halted_cnt", o_cycle_count, 32'd13);
        i_run = 1'b1;
        #1;
        chk("halted_run_ignored_ctl", 32'(ctl), 32'(CTL_OFF));
        tick();
        i_run = 1'b0; i_step = 1'b1;
        #1;
        chk("halted_step_ignored_ctl", 32'(ctl), 32'(CTL_OFF));
        tick();
        i_step = 1'b0;
        #1;
        chk("halted_sticky", 32'(o_halted), 32'd1);
        chk("halted_cnt_frozen", o_cycle_count, 32'd13);

        // ---------------- step mode ----------------
        rst = 1'b0;
        #1;
        chk("rst2_halted_clear", 32'(o_halted), 32'd0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_step = 1'b1;
            #1;
            chk("step_window", 32'(ctl), 32'(CTL_ALL));
            tick();
            i_step = 1'b0;
            #1;
            chk("step_gap", 32'(ctl), 32'(CTL_OFF));
            repeat (4) tick();
        end
        chk("step_cnt3", o_cycle_count, 32'd3);

        // halt while stepping
        i_step = 1'b1; i_halt_instr = 1'b1;
        #1;
        chk("step_halt_ctl", 32'(ctl), 32'(CTL_HALT));
        tick();                         // cnt 4
        clear_inputs();
        #1;
        chk("step_drain_frozen", 32'(ctl), 32'(CTL_OFF));
        chk("step_drain_not_running", 32'(o_running), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("step_drain_pre_halted", 32'(o_halted), 32'd0);
            i_step = 1'b1;
            #1;
            chk("step_drain_ctl", 32'(ctl), 32'(CTL_HALT));
            tick();
            i_step = 1'b0;
            #1;
            tick();
        end
        chk("step_drain_halted", 32'(o_halted), 32'd1);
        chk("step_drain_cnt", o_cycle_count, 32'd8);

        // ---------------- run+step together, run pause ----------------
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_run = 1'b1; i_step = 1'b1;
        #1;
        chk("run_step_same_active", 32'(ctl), 32'(CTL_ALL));
        tick();
        clear_inputs();
        #1;
        chk("run_step_same_idle", 32'(ctl), 32'(CTL_OFF));
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        #1;
        chk("run_again_en", 32'(ctl), 32'(CTL_ALL));
        i_step = 1'b1;
        #1;
        chk("pause_inactive", 32'(ctl), 32'(CTL_OFF));
        tick();
        i_step = 1'b0;
        #1;
        chk("paused_ctl", 32'(ctl), 32'(CTL_OFF));
        chk("paused_not_running", 32'(o_running), 32'd0);
        chk("pause_cnt", o_cycle_count, 32'd1);

        // ---------------- drain cancelled by taken ----------------
        rst = 1'b0;
        tick();
        rst = 1'b1;
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        i_halt_instr = 1'b1;
        #1;
        chk("cancel_halt_ctl", 32'(ctl), 32'(CTL_HALT));
        tick();                         // cnt 1, drain cycle 1
        i_halt_instr = 1'b0;
        #1;
        chk("cancel_drain1_ctl", 32'(ctl), 32'(CTL_HALT));
        tick();                         // cnt 2, drain cycle 2
        i_taken = 1'b1;
        #1;
        chk("cancel_taken_ctl", 32'(ctl), 32'(CTL_TAKEN));
        tick();                         // cnt 3, back in RUN
        i_taken = 1'b0;
        #1;
        chk("cancel_resume_ctl", 32'(ctl), 32'(CTL_ALL));
        chk("cancel_running", 32'(o_running), 32'd1);
        chk("cancel_cnt", o_cycle_count, 32'd3);
        repeat (5) tick();
        chk("cancel_not_halted", 32'(o_halted), 32'd0);
        chk("cancel_still_run", 32'(ctl), 32'(CTL_ALL));

        // ---------------- reset mid-drain ----------------
        i_halt_instr = 1'b1;
        tick();
        i_halt_instr = 1'b0;
        #1;
        chk("mid_drain_ctl", 32'(ctl), 32'(CTL_HALT));
        rst = 1'b0;
        #1;
        chk("mid_drain_reset_ctl", 32'(ctl), 32'(CTL_OFF));
        chk("mid_drain_reset_running", 32'(o_running), 32'd0);
        chk("mid_drain_reset_cnt", o_cycle_count, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("post_reset_idle_ctl", 32'(ctl), 32'(CTL_OFF));
        i_step = 1'b1;
        #1;
        chk("post_reset_step_ctl", 32'(ctl), 32'(CTL_ALL));
        tick();
        i_step = 1'b0;
        #1;
        chk("post_reset_step_cnt", o_cycle_count, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
